// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the lane-order/mode types used by the
// byte deserialiser.
package aes_pkg;

    localparam int AES_BYTE_W      = 8;
    localparam int AES_NB          = 4;
    localparam int AES_STATE_BYTES = 16;

    typedef enum logic {
        LANE_LSB_FIRST = 1'b0,
        LANE_MSB_FIRST = 1'b1
    } lane_order_e;

    // GATHER: words are accepted. STALL: a complete vector waits behind a held output.
    typedef enum logic {
        MODE_GATHER = 1'b0,
        MODE_STALL  = 1'b1
    } deser_mode_e;

    // Arrival slot that fills physical lane k.
    function automatic int lane_slot(input int k, input int n, input lane_order_e ord);
        return (ord == LANE_MSB_FIRST) ? (n - 1 - k) : k;
    endfunction

endpackage

// File: rtl/aes_deser_lane_wr.sv
// Gather-stage lane storage: decodes the per-lane write enable from the arrival
// index and lane order, and presents both the stored lanes and the lanes with
// the current write merged in.
module aes_deser_lane_wr
    import aes_pkg::*;
#(
    parameter int          W     = 8,
    parameter int          N     = 4,
    parameter lane_order_e ORDER = LANE_LSB_FIRST,
    localparam int         IW    = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           wr_en_i,
    input  logic [IW-1:0]  idx_i,
    input  logic [W-1:0]   data_i,
    output logic [N*W-1:0] lanes_o,
    output logic [N*W-1:0] merged_o
);

    logic [N*W-1:0] lanes_q;
    logic [N*W-1:0] lanes_d;
    logic [N-1:0]   lane_we;

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < N; k++) begin
            lane_we[k] = wr_en_i && (idx_i == IW'(lane_slot(k, N, ORDER)));
        end
    end

    // merged_o lets a completing word reach the output stage on its own accept edge.
    always_comb begin
        merged_o = lanes_q;
        for (int k = 0; k < N; k++) begin
            if (lane_we[k]) begin
                merged_o[k*W +: W] = data_i;
            end
        end
    end

    always_comb begin
        lanes_d = clr_i ? '0 : merged_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/aes_deser_buf.sv
// Serial-to-parallel gatherer: N words of W bits become one N*W-bit vector,
// with valid/ready on both sides, a second holding stage and synchronous flush.
module aes_deser_buf
    import aes_pkg::*;
#(
    parameter int          W     = 8,
    parameter int          N     = 4,
    parameter lane_order_e ORDER = LANE_LSB_FIRST,
    localparam int         CW    = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [CW-1:0]  fill_level
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    deser_mode_e    mode_q, mode_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [N*W-1:0] out_data_q, out_data_d;
    logic [N*W-1:0] gather_lanes;
    logic [N*W-1:0] gather_merged;
    logic           accept;
    logic           last_word;
    logic           out_hs;
    logic           out_free;

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // ready never depends on valid on either side.
    assign in_ready  = (mode_q == MODE_GATHER) && !flush;
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (cnt_q == LAST_IDX);
    assign out_hs    = out_valid_q && out_ready;
    assign out_free  = !out_valid_q || out_ready;

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (flush) begin
            cnt_d  = '0;
            mode_d = MODE_GATHER;
        end else if (accept) begin
            cnt_d = last_word ? '0 : cnt_q + 1'b1;
        end

        // A flushed STALL vector is discarded, so only an unflushed one may move out.
        if (last_word && out_free) begin
            out_data_d  = gather_merged;
            out_valid_d = 1'b1;
        end else if (last_word) begin
            mode_d = MODE_STALL;
        end else if ((mode_q == MODE_STALL) && !flush && out_hs) begin
            out_data_d = gather_lanes;
            mode_d     = MODE_GATHER;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_GATHER;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    aes_deser_lane_wr #(
        .W     (W),
        .N     (N),
        .ORDER (ORDER)
    ) u_lane_wr (
        .clk_i    (clk),
        .rst_i    (reset),
        .clr_i    (flush),
        .wr_en_i  (accept),
        .idx_i    (cnt_q),
        .data_i   (in_data),
        .lanes_o  (gather_lanes),
        .merged_o (gather_merged)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fill_level = (mode_q == MODE_STALL) ? CW'(N) : CW'(cnt_q);

endmodule

// File: tb/tb_aes_deser_buf.sv
// Bench for aes_deser_buf: three instances (N=4 LSB-first, N=4 MSB-first,
// N=16) share one stimulus stream, each with its own reference model.
module tb_aes_deser_buf;
    import aes_pkg::*;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [127:0] act,
                       input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, inst, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int          NK    = (g == 2) ? 16 : 4;
        localparam lane_order_e ORD_K = (g == 1) ? LANE_MSB_FIRST : LANE_LSB_FIRST;
        localparam int          CWK   = $clog2(NK + 1);

        logic            rdy;
        logic            ov;
        logic [NK*8-1:0] od;
        logic [CWK-1:0]  fl;

        aes_deser_buf #(.W(8), .N(NK), .ORDER(ORD_K)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (rdy),
            .in_data    (in_data),
            .out_valid  (ov),
            .out_ready  (out_ready),
            .out_data   (od),
            .fill_level (fl)
        );

        // exp_q[0] is the vector on the output, exp_q[1] one parked in the gather stage.
        logic [NK*8-1:0] exp_q[$];
        logic [7:0]      words_q[$];

        always @(negedge clk) begin : model
            int sz;
            bit hs;
            bit acc;
            int lane;
            logic [NK*8-1:0] v;
            if (reset) begin
                chk("rst_out_valid", g, 128'(ov), 128'(0));
                chk("rst_out_data", g, 128'(od), 128'(0));
                chk("rst_fill", g, 128'(fl), 128'(0));
                exp_q.delete();
                words_q.delete();
            end else begin
                sz  = exp_q.size();
                hs  = (sz != 0) && out_ready;
                acc = in_valid && (sz < 2) && !flush;
                chk("in_ready", g, 128'(rdy), 128'((sz < 2) && !flush));
                chk("out_valid", g, 128'(ov), 128'(sz != 0));
                chk("fill_level", g, 128'(fl), 128'((sz == 2) ? NK : words_q.size()));
                if (sz != 0) chk("out_data", g, 128'(od), 128'(exp_q[0]));
                if (flush) begin
                    words_q.delete();
                    if (sz == 2) void'(exp_q.pop_back());
                end
                if (hs) void'(exp_q.pop_front());
                if (acc) begin
                    words_q.push_back(in_data);
                    if (words_q.size() == NK) begin
                        v = '0;
                        for (int i = 0; i < NK; i++) begin
                            lane = (ORD_K == LANE_MSB_FIRST) ? (NK - 1 - i) : i;
                            v[lane*8 +: 8] = words_q[i];
                        end
                        exp_q.push_back(v);
                        words_q.delete();
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        idle(2);
        reset = 1'b0;

        // Basic gather, both lane orders.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(i * 17));
        chk("ord0_valid", 0, 128'(g_inst[0].ov), 128'(1));
        chk("ord0_vec", 0, 128'(g_inst[0].od), 128'h33221100);
        chk("ord1_vec", 1, 128'(g_inst[1].od), 128'h00112233);
        chk("ord0_ready", 0, 128'(g_inst[0].rdy), 128'(1));
        idle(2);

        // N=16 continuous stream.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(8'(i));
            if (i == 14) chk("n16_early", 2, 128'(g_inst[2].ov), 128'(0));
            if (i == 15) chk("n16_vec0", 2, 128'(g_inst[2].od),
                             128'h0f0e0d0c0b0a09080706050403020100);
            if (i == 16) chk("n16_pulse", 2, 128'(g_inst[2].ov), 128'(0));
            if (i == 31) chk("n16_vec1", 2, 128'(g_inst[2].od),
                             128'h1f1e1d1c1b1a19181716151413121110);
        end
        idle(2);

        // Output held: second vector parks in the gather stage.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("hold_ready", 0, 128'(g_inst[0].rdy), 128'(0));
        chk("hold_fill", 0, 128'(g_inst[0].fl), 128'(4));
        chk("hold_vec", 0, 128'(g_inst[0].od), 128'h04030201);
        out_ready = 1'b1;
        idle(1);
        chk("swap_valid", 0, 128'(g_inst[0].ov), 128'(1));
        chk("swap_vec", 0, 128'(g_inst[0].od), 128'h08070605);
        chk("swap_ready", 0, 128'(g_inst[0].rdy), 128'(1));
        idle(2);

        // Flush discards a partial gather.
        do_reset();
        out_ready = 1'b1;
        send(8'hAA);
        send(8'hBB);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCC;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("flush_valid", 0, 128'(g_inst[0].ov), 128'(1));
        chk("flush_vec", 0, 128'(g_inst[0].od), 128'h04030201);
        idle(2);

        // Asynchronous reset mid-vector with a held output.
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) send(8'(i));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 0, 128'(g_inst[0].ov), 128'(0));
        chk("arst_data", 0, 128'(g_inst[0].od), 128'(0));
        chk("arst_fill", 0, 128'(g_inst[0].fl), 128'(0));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
        chk("arst_vec", 0, 128'(g_inst[0].od), 128'h44434241);
        idle(2);

        // Randomised traffic with back-pressure and occasional flush.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            idle(1);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
